// File: rtl/inertial_intf.sv
// IMU SPI front end: powers up, configures the inertial sensor, then reads
// pitch rate and Z acceleration on each data-ready interrupt.
module inertial_intf #(
   parameter logic [15:0] INIT_CYCLES = 16'hFFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        INT,
   input  logic        done,
   input  logic [15:0] resp,
   output logic        wrt,
   output logic [15:0] cmd,
   output logic        vld,
   output logic [15:0] ptch_rt,
   output logic [15:0] AZ
);

   typedef enum logic [3:0] {
      INIT_WAIT,
      CFG0,
      CFG1,
      CFG2,
      CFG3,
      WAIT_INT,
      RD_PL,
      RD_PH,
      RD_AL,
      RD_AH,
      VLD
   } state_t;

   state_t      state_q;
   logic [15:0] timer_q;
   logic        wrt_q;
   logic        vld_q;
   logic [15:0] cmd_q;
   logic [15:0] ptch_q;
   logic [15:0] az_q;
   logic [7:0]  pl_q;
   logic [7:0]  ph_q;
   logic [7:0]  al_q;
   logic [7:0]  ah_q;
   logic        int_ff1_q;
   logic        int_ff2_q;

   // Only the low byte of a read response carries register data.
   logic unused_resp_hi;
   assign unused_resp_hi = ^resp[15:8];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= INIT_WAIT;
         timer_q   <= 16'h0000;
         wrt_q     <= 1'b0;
         vld_q     <= 1'b0;
         cmd_q     <= 16'h0000;
         ptch_q    <= 16'h0000;
         az_q      <= 16'h0000;
         pl_q      <= 8'h00;
         ph_q      <= 8'h00;
         al_q      <= 8'h00;
         ah_q      <= 8'h00;
         int_ff1_q <= 1'b0;
         int_ff2_q <= 1'b0;
      end else begin
         int_ff1_q <= INT;
         int_ff2_q <= int_ff1_q;
         wrt_q     <= 1'b0;
         vld_q     <= 1'b0;
         case (state_q)
            INIT_WAIT: begin
               if (timer_q == INIT_CYCLES) begin
                  state_q <= CFG0;
                  wrt_q   <= 1'b1;
                  cmd_q   <= 16'h0D02;
               end else begin
                  timer_q <= timer_q + 16'd1;
               end
            end
            CFG0: begin
               if (done) begin
                  state_q <= CFG1;
                  wrt_q   <= 1'b1;
                  cmd_q   <= 16'h1053;
               end
            end
            CFG1: begin
               if (done) begin
                  state_q <= CFG2;
                  wrt_q   <= 1'b1;
                  cmd_q   <= 16'h1150;
               end
            end
            CFG2: begin
               if (done) begin
                  state_q <= CFG3;
                  wrt_q   <= 1'b1;
                  cmd_q   <= 16'h1460;
               end
            end
            CFG3: begin
               if (done) begin
                  state_q <= WAIT_INT;
               end
            end
            WAIT_INT: begin
               if (int_ff2_q) begin
                  state_q <= RD_PL;
                  wrt_q   <= 1'b1;
                  cmd_q   <= 16'hA200;
               end
            end
            RD_PL: begin
               if (done) begin
                  pl_q    <= resp[7:0];
                  state_q <= RD_PH;
                  wrt_q   <= 1'b1;
                  cmd_q   <= 16'hA300;
               end
            end
            RD_PH: begin
               if (done) begin
                  ph_q    <= resp[7:0];
                  state_q <= RD_AL;
                  wrt_q   <= 1'b1;
                  cmd_q   <= 16'hAC00;
               end
            end
            RD_AL: begin
               if (done) begin
                  al_q    <= resp[7:0];
                  state_q <= RD_AH;
                  wrt_q   <= 1'b1;
                  cmd_q   <= 16'hAD00;
               end
            end
            RD_AH: begin
               // Outputs load on VLD entry so they are valid alongside vld.
               if (done) begin
                  ah_q    <= resp[7:0];
                  state_q <= VLD;
                  vld_q   <= 1'b1;
                  ptch_q  <= {ph_q, pl_q};
                  az_q    <= {resp[7:0], al_q};
               end
            end
            VLD: begin
               state_q <= WAIT_INT;
            end
            default: begin
               state_q <= INIT_WAIT;
            end
         endcase
      end
   end

   assign wrt     = wrt_q;
   assign cmd     = cmd_q;
   assign vld     = vld_q;
   assign ptch_rt = ptch_q;
   assign AZ      = az_q;

endmodule

// File: tb/tb_inertial_intf.sv
// Directed bench for inertial_intf: config sequence, interrupt-driven
// reads, back-to-back sampling, reset abort and short interrupt pulses.
module tb_inertial_intf;

   logic        clk;
   logic        rst;
   logic        INT;
   logic        done;
   logic [15:0] resp;
   logic        wrt;
   logic [15:0] cmd;
   logic        vld;
   logic [15:0] ptch_rt;
   logic [15:0] AZ;

   int errors;
   int checks;
   int overlap;
   int vld_cnt;

   inertial_intf #(.INIT_CYCLES(16'd16)) dut (
      .clk     (clk),
      .rst     (rst),
      .INT     (INT),
      .done    (done),
      .resp    (resp),
      .wrt     (wrt),
      .cmd     (cmd),
      .vld     (vld),
      .ptch_rt (ptch_rt),
      .AZ      (AZ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wrt === 1'b1 && vld === 1'b1) overlap++;
      if (vld === 1'b1) vld_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // n = negedges waited until wrt seen (0 = already high), -1 on timeout
   task automatic wait_wrt(input int lim, output int n);
      n = -1;
      for (int i = 0; i <= lim && n < 0; i++) begin
         if (wrt === 1'b1) n = i;
         else if (i < lim) @(negedge clk);
      end
   endtask

   // Serve one SPI transaction whose wrt is visible now; done 4 clocks later.
   task automatic txn(input logic [15:0] exp_cmd, input logic [7:0] rb);
      checks++;
      if (cmd !== exp_cmd) begin
         errors++;
         $display("FAIL txn_cmd: got %h want %h", cmd, exp_cmd);
      end
      @(negedge clk);
      checks++;
      if (wrt !== 1'b0) begin
         errors++;
         $display("FAIL wrt_pulse: got %b want 0 (cmd %h)", wrt, exp_cmd);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (cmd !== exp_cmd || wrt !== 1'b0) begin
         errors++;
         $display("FAIL cmd_hold: got %h wrt %b want %h", cmd, wrt, exp_cmd);
      end
      @(negedge clk);
      done = 1'b1;
      resp = {8'hA5, rb};
      @(negedge clk);
      done = 1'b0;
      resp = 16'h0000;
   endtask

   task automatic config_seq();
      logic [15:0] cc [4];
      int n;
      cc = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin
            wait_wrt(6, n);
            checks++;
            if (n !== 0) begin
               errors++;
               $display("FAIL cfg_gap%0d: got %0d want 0", i, n);
            end
         end
         txn(cc[i], 8'h00);
      end
   endtask

   task automatic rd_seq(input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3,
                         input logic [15:0] hold_p, input logic [15:0] hold_a,
                         input logic [15:0] exp_p, input logic [15:0] exp_a,
                         input int drop_at);
      logic [7:0]  b  [4];
      logic [15:0] rc [4];
      int n;
      b  = '{b0, b1, b2, b3};
      rc = '{16'hA200, 16'hA300, 16'hAC00, 16'hAD00};
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin
            wait_wrt(6, n);
            checks++;
            if (n !== 0) begin
               errors++;
               $display("FAIL rd_gap%0d: got %0d want 0", i, n);
            end
         end
         if (i == drop_at) INT = 1'b0;
         txn(rc[i], b[i]);
         checks++;
         if (i < 3) begin
            if (vld !== 1'b0 || ptch_rt !== hold_p || AZ !== hold_a) begin
               errors++;
               $display("FAIL rd_hold%0d: got vld %b %h %h want 0 %h %h",
                        i, vld, ptch_rt, AZ, hold_p, hold_a);
            end
         end else begin
            if (vld !== 1'b1 || ptch_rt !== exp_p || AZ !== exp_a) begin
               errors++;
               $display("FAIL rd_vld: got vld %b %h %h want 1 %h %h",
                        vld, ptch_rt, AZ, exp_p, exp_a);
            end
         end
      end
   endtask

   task automatic test_reset();
      rst  = 1'b1;
      INT  = 1'b0;
      done = 1'b0;
      resp = 16'h0000;
      repeat (3) @(negedge clk);
      checks++;
      if (wrt !== 1'b0 || vld !== 1'b0 || cmd !== 16'h0000 ||
          ptch_rt !== 16'h0000 || AZ !== 16'h0000) begin
         errors++;
         $display("FAIL reset_state: got %b %b %h %h %h want all 0",
                  wrt, vld, cmd, ptch_rt, AZ);
      end
   endtask

   // Release reset and measure clocks to the first wrt, poking done meanwhile.
   task automatic test_init_wait(input string tag);
      int n;
      n = -1;
      rst = 1'b0;
      for (int i = 1; i <= 40 && n < 0; i++) begin
         @(negedge clk);
         if (i == 5) done = 1'b1;
         if (i == 6) done = 1'b0;
         if (wrt === 1'b1) n = i;
      end
      done = 1'b0;
      checks++;
      if (n !== 17) begin
         errors++;
         $display("FAIL %s_first_wrt: got %0d want 17", tag, n);
      end
   endtask

   task automatic test_config();
      int n;
      config_seq();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         done = (i % 2 == 0);
         resp = 16'h00EE;
         if (wrt !== 1'b0 || vld !== 1'b0) n = 99;
      end
      done = 1'b0;
      resp = 16'h0000;
      @(negedge clk);
      checks++;
      if (n === 99 || wrt !== 1'b0 || cmd !== 16'h1460) begin
         errors++;
         $display("FAIL wait_int_idle: got wrt %b cmd %h flag %0d want 0 1460",
                  wrt, cmd, n);
      end
   endtask

   task automatic test_read();
      int n;
      @(negedge clk);
      INT = 1'b1;
      wait_wrt(8, n);
      checks++;
      if (n < 1 || n > 4) begin
         errors++;
         $display("FAIL int_latency: got %0d want 1..4", n);
      end
      rd_seq(8'h34, 8'h12, 8'hCD, 8'hAB, 16'h0000, 16'h0000,
             16'h1234, 16'hABCD, 0);
      wait_wrt(12, n);
      checks++;
      if (n !== -1) begin
         errors++;
         $display("FAIL read_extra: got wrt after %0d want none", n);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      INT = 1'b1;
      wait_wrt(8, n);
      checks++;
      if (n < 1 || n > 4) begin
         errors++;
         $display("FAIL b2b_latency: got %0d want 1..4", n);
      end
      rd_seq(8'h11, 8'h22, 8'h33, 8'h44, 16'h1234, 16'hABCD,
             16'h2211, 16'h4433, 4);
      wait_wrt(4, n);
      checks++;
      if (n < 1 || n > 2) begin
         errors++;
         $display("FAIL b2b_restart: got %0d want 1..2", n);
      end
      rd_seq(8'hFF, 8'hFF, 8'h00, 8'h80, 16'h2211, 16'h4433,
             16'hFFFF, 16'h8000, 3);
      wait_wrt(12, n);
      checks++;
      if (n !== -1 || ptch_rt !== 16'hFFFF || AZ !== 16'h8000) begin
         errors++;
         $display("FAIL b2b_idle: got n %0d %h %h want -1 FFFF 8000",
                  n, ptch_rt, AZ);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      INT = 1'b1;
      wait_wrt(8, n);
      INT = 1'b0;
      txn(16'hA200, 8'h77);
      wait_wrt(6, n);
      checks++;
      if (n !== 0 || cmd !== 16'hA300) begin
         errors++;
         $display("FAIL mid_rd_ph: got n %0d cmd %h want 0 A300", n, cmd);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (wrt !== 1'b0 || vld !== 1'b0 || cmd !== 16'h0000 ||
          ptch_rt !== 16'h0000 || AZ !== 16'h0000) begin
         errors++;
         $display("FAIL mid_reset: got %b %b %h %h %h want all 0",
                  wrt, vld, cmd, ptch_rt, AZ);
      end
      done = 1'b1;
      INT  = 1'b1;
      @(negedge clk);
      checks++;
      if (wrt !== 1'b0 || cmd !== 16'h0000) begin
         errors++;
         $display("FAIL rst_override: got wrt %b cmd %h want 0 0000", wrt, cmd);
      end
      done = 1'b0;
      INT  = 1'b0;
      test_init_wait("rearm");
      config_seq();
      wait_wrt(6, n);
      checks++;
      if (n !== -1) begin
         errors++;
         $display("FAIL rearm_idle: got wrt after %0d want none", n);
      end
   endtask

   task automatic test_int_pulse();
      int n;
      int v0;
      v0 = vld_cnt;
      @(negedge clk);
      #2 INT = 1'b1;
      #10 INT = 1'b0;
      wait_wrt(8, n);
      checks++;
      if (n < 0) begin
         errors++;
         $display("FAIL pulse_start: got timeout want wrt");
      end
      rd_seq(8'h5A, 8'hA5, 8'h01, 8'h02, 16'h0000, 16'h0000,
             16'hA55A, 16'h0201, 5);
      wait_wrt(20, n);
      checks++;
      if (n !== -1 || (vld_cnt - v0) !== 1) begin
         errors++;
         $display("FAIL pulse_once: got n %0d vld %0d want -1 1",
                  n, vld_cnt - v0);
      end
   endtask

   task automatic test_no_overlap();
      checks++;
      if (overlap !== 0) begin
         errors++;
         $display("FAIL wrt_vld_overlap: got %0d want 0", overlap);
      end
   endtask

   initial begin
      errors  = 0;
      checks  = 0;
      overlap = 0;
      vld_cnt = 0;
      test_reset();
      test_init_wait("init");
      test_config();
      test_read();
      test_back_to_back();
      test_reset_mid();
      test_int_pulse();
      test_no_overlap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
